// File: rtl/bootprom_pkg.sv
// Shared types and constants for the boot PROM controller and its arbiter.
package bootprom_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCESS  = 3'd2,
        ST_LATCH   = 3'd3,
        ST_RECOVER = 3'd4
    } state_t;

    localparam int WAIT_W = 4;
    localparam int CPU    = 0;
    localparam int DBG    = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the port not granted last wins.
// Latency: grant is combinational from req; the last-grant pointer updates on the enabled edge.
// Backpressure: none; requests simply wait while en is low.
module rr_arb2
    import bootprom_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = last ? 2'b01 : 2'b10;
        end
    end

    // Reset to DBG so that the CPU wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last <= 1'b1;
        end else if (en && (|req)) begin
            last <= gnt[DBG];
        end
    end

endmodule

// File: rtl/bootprom_ctl.sv
// Shares a 16-bit boot PROM pair (two 27256) between a CPU port and a debug port.
// Latency: request sampled in IDLE -> ack WAIT_STATES+3 cycles later; grants at most every WAIT_STATES+5 cycles.
// Backpressure: requesters hold req until ack; the port not granted simply waits for the next IDLE.
module bootprom_ctl
    import bootprom_pkg::*;
#(
    parameter int WAIT_STATES = 3,
    parameter int ADDR_W      = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [15:0]       cpu_data,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_ack,
    output logic [15:0]       dbg_data,
    output logic [ADDR_W-1:0] prom_addr,
    output logic              prom_ce_n,
    output logic              prom_oe_n,
    input  logic [15:0]       prom_data,
    output logic              busy
);

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wcnt;
    logic [1:0]        gnt;
    logic              gnt_dbg;
    logic              capt_ok;
    logic              gnt_req;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({dbg_req, cpu_req}),
        .en      (state == ST_IDLE),
        .gnt     (gnt)
    );

    assign gnt_req = gnt_dbg ? dbg_req : cpu_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (|gnt) state_nxt = ST_SETUP;
            ST_SETUP:   state_nxt = ST_ACCESS;
            ST_ACCESS:  if (wcnt == '0) state_nxt = ST_LATCH;
            ST_LATCH:   state_nxt = ST_RECOVER;
            ST_RECOVER: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Strobes decode from state and registers only, never from prom_data.
    always_comb begin
        prom_ce_n = 1'b1;
        prom_oe_n = 1'b1;
        busy      = 1'b1;
        cpu_ack   = 1'b0;
        dbg_ack   = 1'b0;
        case (state)
            ST_IDLE:   busy = 1'b0;
            ST_SETUP:  prom_ce_n = 1'b0;
            ST_ACCESS: begin
                prom_ce_n = 1'b0;
                prom_oe_n = 1'b0;
            end
            ST_LATCH: begin
                prom_ce_n = 1'b0;
                cpu_ack   = capt_ok && !gnt_dbg;
                dbg_ack   = capt_ok && gnt_dbg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prom_addr <= '0;
            wcnt      <= '0;
            gnt_dbg   <= 1'b0;
            capt_ok   <= 1'b0;
            cpu_data  <= '0;
            dbg_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        gnt_dbg   <= gnt[DBG];
                        prom_addr <= gnt[DBG] ? dbg_addr : cpu_addr;
                    end
                end
                ST_SETUP: begin
                    wcnt    <= WAIT_W'(WAIT_STATES);
                    capt_ok <= 1'b0;
                end
                ST_ACCESS: begin
                    if (wcnt == '0) begin
                        // A requester that gave up mid-access gets neither data nor ack.
                        if (gnt_req) begin
                            capt_ok <= 1'b1;
                            if (gnt_dbg) dbg_data <= prom_data;
                            else         cpu_data <= prom_data;
                        end
                    end else begin
                        wcnt <= wcnt - WAIT_W'(1);
                    end
                end
                ST_LATCH: capt_ok <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bootprom_ctl.sv
// Bench for bootprom_ctl: one instance with WAIT_STATES=3 (index 0), one with WAIT_STATES=0 (index 1).
module tb_bootprom_ctl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req   [2];
    logic        dbg_req   [2];
    logic        cpu_ack   [2];
    logic        dbg_ack   [2];
    logic        ce_n      [2];
    logic        oe_n      [2];
    logic        busy      [2];
    logic [14:0] cpu_addr  [2];
    logic [14:0] dbg_addr  [2];
    logic [14:0] prom_addr [2];
    logic [15:0] cpu_data  [2];
    logic [15:0] dbg_data  [2];
    logic [15:0] prom_data [2];

    logic [15:0] mem [0:32767];
    logic [15:0] m_data [2][2];
    int          m_last [2];
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    // PROM pair: drives the addressed word only while both CE and OE are low.
    assign prom_data[0] = (!ce_n[0] && !oe_n[0]) ? mem[prom_addr[0]] : 16'h0BAD;
    assign prom_data[1] = (!ce_n[1] && !oe_n[1]) ? mem[prom_addr[1]] : 16'h0BAD;

    bootprom_ctl #(.WAIT_STATES(3), .ADDR_W(15)) dut_w3 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req[0]), .cpu_addr(cpu_addr[0]), .cpu_ack(cpu_ack[0]), .cpu_data(cpu_data[0]),
        .dbg_req(dbg_req[0]), .dbg_addr(dbg_addr[0]), .dbg_ack(dbg_ack[0]), .dbg_data(dbg_data[0]),
        .prom_addr(prom_addr[0]), .prom_ce_n(ce_n[0]), .prom_oe_n(oe_n[0]),
        .prom_data(prom_data[0]), .busy(busy[0])
    );

    bootprom_ctl #(.WAIT_STATES(0), .ADDR_W(15)) dut_w0 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req[1]), .cpu_addr(cpu_addr[1]), .cpu_ack(cpu_ack[1]), .cpu_data(cpu_data[1]),
        .dbg_req(dbg_req[1]), .dbg_addr(dbg_addr[1]), .dbg_ack(dbg_ack[1]), .dbg_data(dbg_data[1]),
        .prom_addr(prom_addr[1]), .prom_ce_n(ce_n[1]), .prom_oe_n(oe_n[1]),
        .prom_data(prom_data[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plans the grant order and timing from the arbitration rules, then runs it cycle by cycle.
    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic serve(input int d, input int n_cpu, input int n_dbg,
                         input logic [14:0] ca0, input logic [14:0] da0);
        int          w, t, lst, p, t_end, act, g;
        int          rem  [2];
        bit          used [2];
        int          g_edge [$];
        int          g_port [$];
        logic [14:0] g_addr [$];
        logic [14:0] cq [$];
        logic [14:0] dq [$];
        logic [14:0] a;
        bit          ack_k, oe_on;
        w = (d == 0) ? 3 : 0;
        rem[0] = n_cpu; rem[1] = n_dbg;
        used[0] = 1'b0; used[1] = 1'b0;
        lst = m_last[d];
        t = 0;
        while (rem[0] > 0 || rem[1] > 0) begin
            if (rem[0] > 0 && rem[1] > 0) p = (lst == 1) ? 0 : 1;
            else                          p = (rem[0] > 0) ? 0 : 1;
            if (!used[p]) a = (p == 0) ? ca0 : da0;
            else          a = 15'($urandom);
            used[p] = 1'b1;
            g_edge.push_back(t); g_port.push_back(p); g_addr.push_back(a);
            if (p == 0) cq.push_back(a); else dq.push_back(a);
            lst = p;
            rem[p]--;
            t += w + 5;
        end
        m_last[d] = lst;
        t_end = t;
        cpu_req[d] = (cq.size() > 0);
        dbg_req[d] = (dq.size() > 0);
        if (cq.size() > 0) cpu_addr[d] = cq[0];
        if (dq.size() > 0) dbg_addr[d] = dq[0];
        for (int k = 1; k <= t_end; k++) begin
            @(negedge clk);
            act = -1;
            g   = 0;
            for (int j = 0; j < g_edge.size(); j++) begin
                if (k >= g_edge[j] + 1 && k <= g_edge[j] + w + 4) begin
                    act = j;
                    g   = g_edge[j];
                end
            end
            ack_k = (act >= 0) && (k == g + w + 3);
            oe_on = (act >= 0) && (k >= g + 2) && (k <= g + w + 2);
            if (ack_k) m_data[d][g_port[act]] = mem[g_addr[act]];
            chk($sformatf("busy d%0d k%0d", d, k), busy[d], act >= 0);
            chk($sformatf("oe_n d%0d k%0d", d, k), oe_n[d], !oe_on);
            if (act < 0 || k == g + w + 4)
                chk($sformatf("ce_n_hi d%0d k%0d", d, k), ce_n[d], 1'b1);
            else if (k <= g + w + 2)
                chk($sformatf("ce_n_lo d%0d k%0d", d, k), ce_n[d], 1'b0);
            chk($sformatf("cpu_ack d%0d k%0d", d, k), cpu_ack[d], ack_k && g_port[act] == 0);
            chk($sformatf("dbg_ack d%0d k%0d", d, k), dbg_ack[d], ack_k && g_port[act] == 1);
            chk($sformatf("cpu_data d%0d k%0d", d, k), cpu_data[d], m_data[d][0]);
            chk($sformatf("dbg_data d%0d k%0d", d, k), dbg_data[d], m_data[d][1]);
            if (act >= 0)
                chk($sformatf("prom_addr d%0d k%0d", d, k), prom_addr[d], g_addr[act]);
            if (ack_k) begin
                if (g_port[act] == 0) begin
                    void'(cq.pop_front());
                    if (cq.size() == 0) cpu_req[d] = 1'b0;
                    else                cpu_addr[d] = cq[0];
                end else begin
                    void'(dq.pop_front());
                    if (dq.size() == 0) dbg_req[d] = 1'b0;
                    else                dbg_addr[d] = dq[0];
                end
            end
        end
    endtask

    initial begin
        logic [14:0] a;
        int          d, nc, nd;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h4EF9;
        for (int i = 0; i < 2; i++) begin
            cpu_req[i] = 1'b0; dbg_req[i] = 1'b0;
            cpu_addr[i] = '0; dbg_addr[i] = '0;
            m_last[i] = 1;
            m_data[i][0] = '0; m_data[i][1] = '0;
        end
        reset_n = 1'b0;
        #2;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst ce_n d%0d", i), ce_n[i], 1'b1);
            chk($sformatf("rst oe_n d%0d", i), oe_n[i], 1'b1);
            chk($sformatf("rst busy d%0d", i), busy[i], 1'b0);
            chk($sformatf("rst addr d%0d", i), prom_addr[i], 15'h0);
            chk($sformatf("rst acks d%0d", i), {cpu_ack[i], dbg_ack[i]}, 2'b00);
            chk($sformatf("rst data d%0d", i), {cpu_data[i], dbg_data[i]}, 32'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Single CPU read of word 0, then a tie with CPU expected first, then sustained contention.
        serve(0, 1, 0, 15'h0000, 15'h0000);
        serve(0, 1, 1, 15'h0010, 15'h0020);
        serve(0, 3, 3, 15'($urandom), 15'($urandom));

        // Zero wait states, debug read at the top of the address space.
        serve(1, 0, 1, 15'h0000, 15'h7FFF);

        // CPU abandons its request during ACCESS: no ack, no data change, normal timing.
        a = 15'($urandom);
        cpu_addr[0] = a;
        cpu_req[0]  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("drop cpu_ack k%0d", k), cpu_ack[0], 1'b0);
            chk($sformatf("drop cpu_data k%0d", k), cpu_data[0], m_data[0][0]);
            chk($sformatf("drop busy k%0d", k), busy[0], k <= 7);
            if (k == 2) cpu_req[0] = 1'b0;
        end
        m_last[0] = 0;
        serve(0, 1, 1, 15'($urandom), 15'($urandom));

        // Reset pulsed in the middle of an access.
        dbg_addr[0] = 15'($urandom);
        dbg_req[0]  = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst ce_n", ce_n[0], 1'b1);
        chk("midrst oe_n", oe_n[0], 1'b1);
        chk("midrst busy", busy[0], 1'b0);
        chk("midrst dbg_ack", dbg_ack[0], 1'b0);
        chk("midrst data w3", {cpu_data[0], dbg_data[0]}, 32'h0);
        chk("midrst data w0", {cpu_data[1], dbg_data[1]}, 32'h0);
        dbg_req[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_last[i] = 1;
            m_data[i][0] = '0; m_data[i][1] = '0;
        end
        @(negedge clk);
        reset_n = 1'b1;
        serve(0, 1, 1, 15'($urandom), 15'($urandom));

        // Random traffic on both instances.
        for (int r = 0; r < 10; r++) begin
            d  = $urandom_range(0, 1);
            nc = $urandom_range(0, 2);
            nd = $urandom_range(0, 2);
            if (nc == 0 && nd == 0) nc = 1;
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                chk($sformatf("gap busy r%0d", r), {busy[0], busy[1]}, 2'b00);
            end
            serve(d, nc, nd, 15'($urandom), 15'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
